pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch stage; sits directly downstream of PC_control.
- Consumes PC_update/PC_src redirects from PC_control, issues word addresses to instruction memory and registers the fetched instruction into the IF/ID boundary.
- Holds the hardware return-address stack (RAS) whose top-of-stack feeds PC_control's PC_stack_pointer via the pipeline.

---
 rtl/pc_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction-fetch stage into IF/ID, and the hardware
// return-address stack whose top feeds PC_control through the pipeline.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned RAS_AW       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_src,
    input  logic [31:0] PC_update,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus_1,
    input  logic        ras_push,
    input  logic [31:0] ras_push_addr,
    input  logic        ras_pop,
    output logic [31:0] ras_top,
    output logic        ras_empty,
    output logic        ras_full,
    output logic        ras_err
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 1 << RAS_AW;
    localparam int unsigned CNT_W = RAS_AW + 1;

    // Fetch state
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;

    // RAS state
    logic [XLEN-1:0]   ras_mem_q [DEPTH];
    logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
    logic              ras_err_q, ras_err_d;
    logic              ras_we_c;
    logic [RAS_AW-1:0] ras_waddr_c;
    logic [RAS_AW-1:0] ras_top_idx_c;
    logic              ras_empty_c;
    logic              ras_full_c;

    // Fetch next-state: redirect > stall > bubble > advance
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_out_d      = pc_out_q;
        if (PC_src) begin
            pc_d          = PC_update;
            instr_valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (!imem_valid) begin
            instr_valid_d = 1'b0;
        end else begin
            instr_d       = imem_data;
            pc_out_d      = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + XLEN'(1);
        end
    end

    // Fetch registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_out_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_out_q      <= pc_out_d;
        end
    end

    assign ras_empty_c   = (ras_cnt_q == '0);
    assign ras_full_c    = (ras_cnt_q == CNT_W'(DEPTH));
    assign ras_top_idx_c = RAS_AW'(ras_cnt_q - CNT_W'(1));

    // RAS next-state; push+pop on a non-empty stack replaces the top
    always_comb begin
        ras_cnt_d   = ras_cnt_q;
        ras_err_d   = ras_err_q;
        ras_we_c    = 1'b0;
        ras_waddr_c = '0;
        case ({ras_push, ras_pop})
            2'b10: begin
                if (ras_full_c) begin
                    ras_err_d = 1'b1;
                end else begin
                    ras_we_c    = 1'b1;
                    ras_waddr_c = RAS_AW'(ras_cnt_q);
                    ras_cnt_d   = ras_cnt_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (ras_empty_c) begin
                    ras_err_d = 1'b1;
                end else begin
                    ras_cnt_d = ras_cnt_q - CNT_W'(1);
                end
            end
            2'b11: begin
                ras_we_c = 1'b1;
                if (ras_empty_c) begin
                    ras_waddr_c = '0;
                    ras_cnt_d   = CNT_W'(1);
                end else begin
                    ras_waddr_c = ras_top_idx_c;
                end
            end
            default: begin
                ras_cnt_d = ras_cnt_q;
            end
        endcase
    end

    // RAS count and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_cnt_q <= '0;
            ras_err_q <= 1'b0;
        end else begin
            ras_cnt_q <= ras_cnt_d;
            ras_err_q <= ras_err_d;
        end
    end

    // RAS storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (ras_we_c) begin
            ras_mem_q[ras_waddr_c] <= ras_push_addr;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign PC_out      = pc_out_q;
    assign PC_plus_1   = pc_out_q + XLEN'(1);
    assign ras_top     = ras_empty_c ? '0 : ras_mem_q[ras_top_idx_c];
    assign ras_empty   = ras_empty_c;
    assign ras_full    = ras_full_c;
    assign ras_err     = ras_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch sequencing, stall, redirect,
// bubbles, PC wrap, reset and the return-address stack.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_src;
    logic [31:0] PC_update;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC_out;
    logic [31:0] PC_plus_1;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .RESET_VECTOR(32'h40),
        .RAS_AW      (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PC_src       (PC_src),
        .PC_update    (PC_update),
        .stall        (stall),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .imem_valid   (imem_valid),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .PC_out       (PC_out),
        .PC_plus_1    (PC_plus_1),
        .ras_push     (ras_push),
        .ras_push_addr(ras_push_addr),
        .ras_pop      (ras_pop),
        .ras_top      (ras_top),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_err      (ras_err)
    );

    always #5 clk = ~clk;

    // Instruction memory model: word at address A is A + 'h100
    assign imem_data = imem_addr + 32'h100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_instr,
                             input logic [31:0] e_pc);
        check({tag, ".addr"}, imem_addr, e_addr);
        check({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
        if (e_valid) begin
            check({tag, ".instr"}, instr, e_instr);
            check({tag, ".pc_out"}, PC_out, e_pc);
            check({tag, ".pc_plus_1"}, PC_plus_1, e_pc + 32'd1);
        end
    endtask

    task automatic ras_op(input logic push, input logic pop, input logic [31:0] addr);
        ras_push      = push;
        ras_pop       = pop;
        ras_push_addr = addr;
        step();
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
    endtask

    task automatic chk_ras(input string tag, input logic [31:0] e_top,
                           input logic e_empty, input logic e_full, input logic e_err);
        check({tag, ".top"}, ras_top, e_top);
        check({tag, ".empty"}, 32'(ras_empty), 32'(e_empty));
        check({tag, ".full"}, 32'(ras_full), 32'(e_full));
        check({tag, ".err"}, 32'(ras_err), 32'(e_err));
    endtask

    initial begin
        rst = 1'b1; PC_src = 1'b0; PC_update = '0; stall = 1'b0;
        imem_valid = 1'b1; ras_push = 1'b0; ras_pop = 1'b0; ras_push_addr = '0;
        step();
        step();
        // Reset state
        check("rst.addr", imem_addr, 32'h40);
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.instr", instr, 32'h0);
        check("rst.pc_out", PC_out, 32'h0);
        check("rst.pc_plus_1", PC_plus_1, 32'h1);
        chk_ras("rst.ras", 32'h0, 1'b1, 1'b0, 1'b0);

        rst = 1'b0;
        step(); chk_fetch("f1", 32'h41, 1'b1, 32'h140, 32'h40);
        step(); chk_fetch("f2", 32'h42, 1'b1, 32'h141, 32'h41);

        // Stall two cycles at PC 42
        stall = 1'b1;
        step(); chk_fetch("st1", 32'h42, 1'b1, 32'h141, 32'h41);
        step(); chk_fetch("st2", 32'h42, 1'b1, 32'h141, 32'h41);
        stall = 1'b0;
        step(); chk_fetch("st_resume", 32'h43, 1'b1, 32'h142, 32'h42);

        // Redirect overrides stall
        PC_src = 1'b1; PC_update = 32'h200; stall = 1'b1;
        step(); chk_fetch("rd1", 32'h200, 1'b0, 32'h0, 32'h0);
        PC_src = 1'b0; stall = 1'b0;
        step(); chk_fetch("rd2", 32'h201, 1'b1, 32'h300, 32'h200);

        // Three bubbles: PC holds, nothing skipped
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_fetch($sformatf("bub%0d", i), 32'h201, 1'b0, 32'h0, 32'h0);
        end
        imem_valid = 1'b1;
        step(); chk_fetch("bub_resume", 32'h202, 1'b1, 32'h301, 32'h201);

        // PC wrap at all-ones; PC_plus_1 wraps as well
        PC_src = 1'b1; PC_update = 32'hFFFF_FFFF;
        step(); chk_fetch("wr1", 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
        PC_src = 1'b0;
        step(); chk_fetch("wr2", 32'h0, 1'b1, 32'h0000_00FF, 32'hFFFF_FFFF);
        check("wr2.pc_plus_1_wrap", PC_plus_1, 32'h0);

        // RAS fill to full then overflow
        ras_op(1'b1, 1'b0, 32'd10); chk_ras("push10", 32'd10, 1'b0, 1'b0, 1'b0);
        ras_op(1'b1, 1'b0, 32'd20); chk_ras("push20", 32'd20, 1'b0, 1'b0, 1'b0);
        ras_op(1'b1, 1'b0, 32'd30); chk_ras("push30", 32'd30, 1'b0, 1'b0, 1'b0);
        ras_op(1'b1, 1'b0, 32'd40); chk_ras("push40", 32'd40, 1'b0, 1'b1, 1'b0);
        ras_op(1'b1, 1'b0, 32'd50); chk_ras("push50_ovf", 32'd40, 1'b0, 1'b1, 1'b1);
        // Drain and underflow
        ras_op(1'b0, 1'b1, 32'd0); chk_ras("pop1", 32'd30, 1'b0, 1'b0, 1'b1);
        ras_op(1'b0, 1'b1, 32'd0); chk_ras("pop2", 32'd20, 1'b0, 1'b0, 1'b1);
        ras_op(1'b0, 1'b1, 32'd0); chk_ras("pop3", 32'd10, 1'b0, 1'b0, 1'b1);
        ras_op(1'b0, 1'b1, 32'd0); chk_ras("pop4", 32'd0, 1'b1, 1'b0, 1'b1);
        ras_op(1'b0, 1'b1, 32'd0); chk_ras("pop5_udf", 32'd0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-operation, no clock edge needed
        rst = 1'b1;
        #1;
        check("arst.addr", imem_addr, 32'h40);
        check("arst.valid", 32'(instr_valid), 32'd0);
        check("arst.pc_out", PC_out, 32'h0);
        chk_ras("arst.ras", 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step(); chk_fetch("post_rst", 32'h41, 1'b1, 32'h140, 32'h40);

        // Replace top with simultaneous push/pop
        ras_op(1'b1, 1'b0, 32'd10);
        ras_op(1'b1, 1'b0, 32'd20); chk_ras("pp_pre", 32'd20, 1'b0, 1'b0, 1'b0);
        ras_op(1'b1, 1'b1, 32'd77); chk_ras("pp_replace", 32'd77, 1'b0, 1'b0, 1'b0);
        ras_op(1'b0, 1'b1, 32'd0);  chk_ras("pp_below", 32'd10, 1'b0, 1'b0, 1'b0);
        ras_op(1'b0, 1'b1, 32'd0);  chk_ras("pp_drain", 32'd0, 1'b1, 1'b0, 1'b0);
        // Simultaneous push/pop on empty acts as push
        ras_op(1'b1, 1'b1, 32'd5);  chk_ras("pp_empty", 32'd5, 1'b0, 1'b0, 1'b0);
        ras_op(1'b0, 1'b1, 32'd0);  chk_ras("pp_empty_cnt1", 32'd0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
